// File: rtl/fabric_config_loader_if.sv
// Bundles the configuration byte stream and the configuration-memory write
// port of the fabric configuration loader. The master side is whoever feeds
// bytes in and watches the result; the slave side is the loader itself.
interface fabric_config_loader_if #(
   parameter int unsigned WORD_W = 33,
   parameter int unsigned ADDR_W = 4
);
   logic [7:0]        in_byte;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] cfg_addr;
   logic [WORD_W-1:0] cfg_word;
   logic              cfg_we;
   logic              fabric_clear;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output in_byte, in_valid,
      input  in_ready, cfg_addr, cfg_word, cfg_we, fabric_clear, busy, done, err
   );

   modport slave (
      input  in_byte, in_valid,
      output in_ready, cfg_addr, cfg_word, cfg_we, fabric_clear, busy, done, err
   );
endinterface

// File: rtl/fabric_config_loader.sv
// Fabric configuration loader: receives a framed byte stream (sync byte,
// NUM_WORDS little-endian 5-byte words, XOR checksum byte), writes each
// assembled 33-bit word to the fabric configuration memory, and releases the
// fabric from clear only once a complete frame with a good checksum arrives.
module fabric_config_loader #(
   parameter int unsigned WORD_W    = 33,
   parameter int unsigned NUM_WORDS = 14,
   parameter int unsigned ADDR_W    = 4,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic                  clock,
   input  logic                  clear,
   fabric_config_loader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_e;

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_WORDS - 1);
   localparam logic [2:0]        LAST_BYTE = 3'd4;

   state_e            state_q;
   logic [2:0]        byte_cnt_q;
   logic [ADDR_W-1:0] word_idx_q;
   logic [31:0]       asm_q;        // bytes 0..3 of the word being assembled
   logic [7:0]        csum_q;       // running XOR of payload bytes
   logic              in_ready_q;
   logic [ADDR_W-1:0] cfg_addr_q;
   logic [WORD_W-1:0] cfg_word_q;
   logic              cfg_we_q;
   logic              fabric_clear_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;

   logic              accept;
   logic [31:0]       asm_d;
   logic [7:0]        csum_d;
   logic [WORD_W-1:0] word_d;

   // A transfer happens only when the registered ready meets a valid byte.
   assign accept = bus.in_valid && in_ready_q;

   // Little-endian assembly: each new byte enters at the top and the older
   // bytes move down, so after four bytes byte0 sits in bits [7:0].
   assign asm_d  = {bus.in_byte, asm_q[31:8]};
   assign csum_d = csum_q ^ bus.in_byte;

   // The fifth byte contributes only its bit 0, which becomes word bit 32.
   assign word_d = {bus.in_byte[0], asm_q};

   // Frame-level FSM with all outputs registered alongside the state.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q        <= S_IDLE;
         byte_cnt_q     <= '0;
         word_idx_q     <= '0;
         asm_q          <= '0;
         csum_q         <= '0;
         in_ready_q     <= 1'b1;
         cfg_addr_q     <= '0;
         cfg_word_q     <= '0;
         cfg_we_q       <= 1'b0;
         fabric_clear_q <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below sees
         // the pre-edge register values regardless of statement order; the
         // default low here makes cfg_we a single-cycle strobe.
         cfg_we_q <= 1'b0;

         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               // Anything other than the sync marker is dropped on the floor.
               if (accept && (bus.in_byte == SYNC_BYTE)) begin
                  state_q        <= S_COLLECT;
                  busy_q         <= 1'b1;
                  done_q         <= 1'b0;
                  err_q          <= 1'b0;
                  fabric_clear_q <= 1'b0;
                  byte_cnt_q     <= '0;
                  word_idx_q     <= '0;
                  asm_q          <= '0;
                  csum_q         <= '0;
               end
            end

            S_COLLECT: begin
               // A sync-valued byte here is ordinary payload.
               if (accept) begin
                  csum_q <= csum_d;
                  if (byte_cnt_q == LAST_BYTE) begin
                     byte_cnt_q <= '0;
                     state_q    <= S_WRITE;
                     in_ready_q <= 1'b0;
                     cfg_we_q   <= 1'b1;
                     cfg_addr_q <= word_idx_q;
                     cfg_word_q <= word_d;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 3'd1;
                     asm_q      <= asm_d;
                  end
               end
            end

            S_WRITE: begin
               // The strobe is already on the bus; just advance the index.
               in_ready_q <= 1'b1;
               word_idx_q <= word_idx_q + 1'b1;
               state_q    <= (word_idx_q == LAST_IDX) ? S_CHECK : S_COLLECT;
            end

            S_CHECK: begin
               if (accept) begin
                  busy_q <= 1'b0;
                  if (bus.in_byte == csum_q) begin
                     state_q        <= S_DONE;
                     done_q         <= 1'b1;
                     fabric_clear_q <= 1'b1;
                  end else begin
                     state_q <= S_ERROR;
                     err_q   <= 1'b1;
                  end
               end
            end

            default: begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b1;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.cfg_addr     = cfg_addr_q;
   assign bus.cfg_word     = cfg_word_q;
   assign bus.cfg_we       = cfg_we_q;
   assign bus.fabric_clear = fabric_clear_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Bench for the fabric configuration loader. Frames are built from a word
// image; each expected memory write is queued as its fifth byte is driven and
// is checked by a monitor when the loader raises cfg_we.
module tb_fabric_config_loader;

   localparam int unsigned WORD_W    = 33;
   localparam int unsigned NUM_WORDS = 14;
   localparam int unsigned ADDR_W    = 4;
   localparam logic [7:0]  SYNC      = 8'hA5;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] word;
   } wr_t;

   logic clock = 1'b0;
   logic clear = 1'b0;

   always #5 clock = ~clock;

   fabric_config_loader_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

   fabric_config_loader #(
      .WORD_W   (WORD_W),
      .NUM_WORDS(NUM_WORDS),
      .ADDR_W   (ADDR_W),
      .SYNC_BYTE(SYNC)
   ) dut (
      .clock(clock),
      .clear(clear),
      .bus  (bus)
   );

   int pass_cnt = 0;
   int fail_cnt = 0;
   int wr_cnt   = 0;

   wr_t               exp_q[$];
   wr_t               exp_e;
   logic [WORD_W-1:0] img_word[NUM_WORDS];
   logic [6:0]        img_hi[NUM_WORDS];    // bits [7:1] sent in each byte4
   logic [7:0]        csum_model;
   logic [ADDR_W-1:0] last_addr;
   logic [WORD_W-1:0] last_word;

   // Monitor: handshake invariant, scoreboard pop on each write, hold check.
   always @(negedge clock) begin
      if (!clear) begin
         last_addr = '0;
         last_word = '0;
      end else begin
         if (bus.in_ready !== ~bus.cfg_we) begin
            fail_cnt++;
            $display("FAIL ready_vs_we: in_ready=%b cfg_we=%b, want in_ready = !cfg_we", bus.in_ready, bus.cfg_we);
         end else pass_cnt++;

         if (bus.cfg_we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               fail_cnt++;
               $display("FAIL cfg_write_unexpected: addr=%0d word=%h, want no write", bus.cfg_addr, bus.cfg_word);
            end else begin
               exp_e = exp_q.pop_front();
               if (bus.cfg_addr !== exp_e.addr || bus.cfg_word !== exp_e.word) begin
                  fail_cnt++;
                  $display("FAIL cfg_write: got addr=%0d word=%h, want addr=%0d word=%h",
                           bus.cfg_addr, bus.cfg_word, exp_e.addr, exp_e.word);
               end else pass_cnt++;
            end
            last_addr = bus.cfg_addr;
            last_word = bus.cfg_word;
         end else begin
            if (bus.cfg_addr !== last_addr || bus.cfg_word !== last_word) begin
               fail_cnt++;
               $display("FAIL cfg_hold: got addr=%0d word=%h, want held addr=%0d word=%h",
                        bus.cfg_addr, bus.cfg_word, last_addr, last_word);
            end else pass_cnt++;
         end
      end
   end

   // Global time limit so a stuck design still ends the run.
   initial begin
      #500_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Drive one byte starting at a falling edge; returns at the falling edge
   // right after the rising edge that transferred it.
   task automatic send_byte(input logic [7:0] b, input bit stall);
      int waited;
      waited = 0;
      if (stall) begin
         bus.in_valid = 1'b0;
         @(negedge clock);
      end
      bus.in_byte  = b;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1) begin
         @(negedge clock);
         waited++;
         if (waited > 20) begin
            fail_cnt++;
            $display("FAIL accept_timeout: byte %h not accepted in 20 cycles, in_ready=%b", b, bus.in_ready);
            break;
         end
      end
      @(negedge clock);
      bus.in_valid = 1'b0;
   endtask

   // Send the first n words of the image, queuing each expected write.
   task automatic send_words(input int n, input bit stall);
      for (int w = 0; w < n; w++) begin
         for (int b = 0; b < 5; b++) begin
            logic [7:0] by;
            by = (b == 4) ? {img_hi[w], img_word[w][32]} : img_word[w][8*b +: 8];
            if (b == 4) exp_q.push_back('{addr: ADDR_W'(w), word: {by[0], img_word[w][31:0]}});
            csum_model ^= by;
            send_byte(by, stall);
         end
      end
   endtask

   task automatic send_head(input bit stall);
      csum_model = 8'h00;
      send_byte(SYNC, stall);
      send_words(NUM_WORDS, stall);
   endtask

   task automatic send_tail(input bit bad, input bit stall);
      send_byte(bad ? (csum_model ^ 8'h01) : csum_model, stall);
   endtask

   task automatic load_index_image();
      for (int i = 0; i < NUM_WORDS; i++) begin
         img_word[i] = WORD_W'(i);
         img_hi[i]   = 7'h00;
      end
   endtask

   task automatic check_writes(input string name, input int want);
      if (wr_cnt !== want || exp_q.size() != 0) begin
         fail_cnt++;
         $display("FAIL %s_writes: got %0d writes (%0d pending), want %0d (0 pending)", name, wr_cnt, exp_q.size(), want);
      end else pass_cnt++;
   endtask

   task automatic check_flags(input string name, input logic want_done, input logic want_err,
                              input logic want_fc, input logic want_busy);
      if ({bus.done, bus.err, bus.fabric_clear, bus.busy} !== {want_done, want_err, want_fc, want_busy}) begin
         fail_cnt++;
         $display("FAIL %s_flags: got done=%b err=%b fabric_clear=%b busy=%b, want %b %b %b %b", name,
                  bus.done, bus.err, bus.fabric_clear, bus.busy, want_done, want_err, want_fc, want_busy);
      end else pass_cnt++;
   endtask

   task automatic test_reset();
      bus.in_byte  = 8'h00;
      bus.in_valid = 1'b0;
      @(negedge clock);
      if (bus.in_ready !== 1'b1 || bus.cfg_we !== 1'b0) begin
         fail_cnt++;
         $display("FAIL reset_handshake: got in_ready=%b cfg_we=%b, want 1 0", bus.in_ready, bus.cfg_we);
      end else pass_cnt++;
      if (bus.cfg_addr !== '0 || bus.cfg_word !== '0) begin
         fail_cnt++;
         $display("FAIL reset_cfg: got addr=%0d word=%h, want 0 0", bus.cfg_addr, bus.cfg_word);
      end else pass_cnt++;
      check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      #2 clear = 1'b1;
      @(negedge clock);
      check_flags("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_good_frame();
      load_index_image();
      wr_cnt = 0;
      send_head(1'b0);
      @(negedge clock);
      check_flags("good_pre_csum", 1'b0, 1'b0, 1'b0, 1'b1);
      send_tail(1'b0, 1'b0);
      check_writes("good", NUM_WORDS);
      check_flags("good_done", 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_bad_checksum();
      load_index_image();
      wr_cnt = 0;
      send_head(1'b0);
      send_tail(1'b1, 1'b0);
      check_writes("bad", NUM_WORDS);
      check_flags("bad_err", 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clock);
      check_flags("bad_err_hold", 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_byte4_mask();
      load_index_image();
      img_word[0] = 33'h1_FFFF_FFFF;
      img_hi[0]   = 7'h7F;
      wr_cnt = 0;
      send_head(1'b0);
      send_tail(1'b0, 1'b0);
      check_writes("mask", NUM_WORDS);
      check_flags("mask_done", 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_junk_and_stalls();
      load_index_image();
      wr_cnt = 0;
      send_byte(8'h00, 1'b1);
      send_byte(8'h3C, 1'b1);
      check_flags("junk_ignored", 1'b1, 1'b0, 1'b1, 1'b0);
      send_head(1'b1);
      send_tail(1'b0, 1'b1);
      check_writes("stall", NUM_WORDS);
      check_flags("stall_done", 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_frame();
      load_index_image();
      wr_cnt = 0;
      csum_model = 8'h00;
      send_byte(SYNC, 1'b0);
      send_words(3, 1'b0);
      repeat (2) @(negedge clock);
      check_writes("midreset", 3);
      #2 clear = 1'b0;
      #1;
      if (bus.in_ready !== 1'b1 || bus.cfg_we !== 1'b0 || bus.cfg_addr !== '0 || bus.cfg_word !== '0) begin
         fail_cnt++;
         $display("FAIL midreset_outputs: got in_ready=%b cfg_we=%b addr=%0d word=%h, want 1 0 0 0",
                  bus.in_ready, bus.cfg_we, bus.cfg_addr, bus.cfg_word);
      end else pass_cnt++;
      check_flags("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      #2 clear = 1'b1;
      @(negedge clock);
      wr_cnt = 0;
      send_head(1'b0);
      send_tail(1'b0, 1'b0);
      check_writes("after_reset", NUM_WORDS);
      check_flags("after_reset_done", 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reload();
      load_index_image();
      img_word[5] = 33'h0_0000_A5A5;   // sync value inside the payload
      wr_cnt = 0;
      csum_model = 8'h00;
      send_byte(SYNC, 1'b0);
      check_flags("reload_sync", 1'b0, 1'b0, 1'b0, 1'b1);
      send_words(NUM_WORDS, 1'b0);
      send_tail(1'b0, 1'b0);
      check_writes("reload", NUM_WORDS);
      check_flags("reload_done", 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_byte4_mask();
      test_junk_and_stalls();
      test_reset_mid_frame();
      test_reload();
      repeat (2) @(negedge clock);
      $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
      $finish;
   end

endmodule

// File: doc/fabric_config_loader.md
Name: fabric_config_loader

Overview:
- Upstream configuration stage for the fpga fabric; loads the configuration image before the fabric runs.
- Receives the image as a byte stream with a valid/ready handshake.
- Assembles the 33-bit configuration words and writes each one, with its word index, to the fabric configuration memory.
- Holds the fabric in clear until the whole image has been received and its checksum matches.

Parameters:
- WORD_W, 33: configuration word width in bits.
- NUM_WORDS, 14: words per image (index 0 = select, 1 = lta, 2..3 = sb a-d, 4..11 = lt_0..7, 12..13 = sb e).
- ADDR_W, 4: width of cfg_addr; must satisfy 2^ADDR_W >= NUM_WORDS.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clock  input  1  system clock, rising edge.
- clear  input  1  asynchronous, active-low reset.
- in_byte  input  8  stream data byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  loader accepts in_byte this cycle; a transfer occurs when in_valid and in_ready are both high.
- cfg_addr  output  ADDR_W  index of the configuration word being written.
- cfg_word  output  WORD_W  assembled configuration word.
- cfg_we  output  1  one-cycle write strobe for cfg_addr/cfg_word.
- fabric_clear  output  1  active-low clear to the fabric; 0 holds the fabric in reset.
- busy  output  1  a frame is in progress.
- done  output  1  sticky: last image loaded and checksum good.
- err  output  1  sticky: last image had a checksum mismatch.

Behaviour:
- Reset (clear=0, asynchronous):
  - state IDLE.
  - All outputs 0 except in_ready=1.
  - Word and byte counters, assembly register and checksum cleared.
- Frame format: SYNC_BYTE, then NUM_WORDS*5 payload bytes, then one checksum byte.
  - Each word occupies 5 bytes, little-endian: byte0 = bits[7:0] ... byte4 bit0 = bit 32.
  - Bits [7:1] of byte4 are ignored.
- Checksum: XOR of all payload bytes (SYNC_BYTE excluded) must equal the checksum byte.
- FSM states: IDLE, COLLECT, WRITE, CHECK, DONE, ERROR.
- IDLE / DONE / ERROR:
  - in_ready=1.
  - An accepted byte equal to SYNC_BYTE moves to COLLECT, clears done, err and counters, and drives fabric_clear=0.
  - Any other accepted byte is discarded.
- COLLECT:
  - in_ready=1 and busy=1.
  - Each accepted byte shifts into the assembly register and is XORed into the running checksum.
  - After the 5th byte of a word, go to WRITE.
- WRITE: exactly one cycle.
  - in_ready=0, cfg_we=1, cfg_addr = word index, cfg_word = assembled word.
  - Word index increments.
  - Next state is COLLECT, or CHECK if the index just written was NUM_WORDS-1.
- CHECK:
  - in_ready=1.
  - On acceptance of the checksum byte: if it matches, go to DONE with done=1 and fabric_clear=1 on the next cycle.
  - Otherwise go to ERROR with err=1 and fabric_clear kept at 0.
- Latency: the 5th byte of a word accepted at edge t gives cfg_we high during the cycle following t, for one cycle.
- cfg_addr and cfg_word hold their values when cfg_we=0.
- A SYNC_BYTE value received inside a frame is payload, not a restart.
- in_valid low stalls the frame indefinitely; there is no timeout.
- Reset mid-frame:
  - Immediate return to IDLE with fabric_clear=0.
  - Words already written are not undone; the fabric stays held in clear until a later good frame completes.
- Maximum throughput: 5 bytes per 6 cycles during payload.

Test Plan:
- Good frame: sync, then words 0..13 = 33'h0_0000_0000 + index, then correct checksum -> 14 cfg_we pulses with cfg_addr 0..13 and cfg_word equal to its index; done=1, fabric_clear=1 one cycle after the checksum byte.
- Bad checksum: same frame with the checksum XOR 8'h01 -> all 14 writes occur; err=1, done=0, fabric_clear stays 0.
- Bit-32/byte4 masking: word 0 sent as bytes FF,FF,FF,FF,FF -> cfg_word = 33'h1_FFFF_FFFF; the checksum still covers the full byte FF.
- Leading junk and stalls: bytes 00,3C before sync, plus in_valid toggled every other cycle -> junk ignored, results identical to the good-frame case; in_ready=0 exactly during each WRITE cycle.
- Reset mid-frame: assert clear=0 after 3 words -> outputs return to reset values immediately; a subsequent good frame loads normally and reaches done=1.
- Reload: a second good frame after DONE -> done clears and fabric_clear drops to 0 on the sync byte, then both return to 1 after the new checksum byte.
